// File: rtl/ser2par_reg.sv
// Serial-to-parallel register stage: shifts in one bit per accepted cycle and
// presents each WIDTH-bit word through a one-entry valid/ready output register.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   a        serial data bit
//   a_valid  a holds a bit to accept
//   a_ready  stage can accept a bit this cycle (combinational)
//   s        assembled parallel word
//   s_valid  s holds a complete word
//   s_ready  downstream consumes s this cycle
//   cnt      bits accepted into the current partial word
module ser2par_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] s,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [CW-1:0]    cnt
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             sv_q, sv_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] sh_nxt;
    logic             last;
    logic             accept;
    logic             drain;

    assign last    = (cnt_q == LAST);
    // Only the word-completing bit can stall, and only on a full,
    // undrained output slot.
    assign a_ready = !last || !sv_q || s_ready;
    assign accept  = a_valid && a_ready;
    assign drain   = sv_q && s_ready;

    always_comb begin
        if (MSB_FIRST) begin
            sh_nxt = {sh_q[WIDTH-2:0], a};
        end else begin
            sh_nxt = {a, sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        s_d   = s_q;
        sv_d  = sv_q;
        if (drain) begin
            sv_d = 1'b0;
        end
        // A load on the same edge as a drain wins, keeping s_valid high.
        if (accept) begin
            sh_d = sh_nxt;
            if (last) begin
                cnt_d = '0;
                s_d   = sh_nxt;
                sv_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            s_q   <= '0;
            sv_q  <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            s_q   <= s_d;
            sv_q  <= sv_d;
        end
    end

    assign s       = s_q;
    assign s_valid = sv_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_ser2par_reg.sv
// Scoreboard bench for ser2par_reg: MSB-first and LSB-first instances share
// stimulus; a monitor pops expected words on every output handshake.
module tb_ser2par_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0;
    logic       a_valid = 1'b0;
    logic       s_ready = 1'b1;
    logic       a_ready, a_ready_l;
    logic [7:0] s, s_l;
    logic       s_valid, s_valid_l;
    logic [2:0] cnt, cnt_l;

    ser2par_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid),
        .a_ready(a_ready), .s(s), .s_valid(s_valid),
        .s_ready(s_ready), .cnt(cnt)
    );

    ser2par_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid),
        .a_ready(a_ready_l), .s(s_l), .s_valid(s_valid_l),
        .s_ready(s_ready), .cnt(cnt_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    int         drain_t[$];
    bit         stream_on = 1'b0;
    bit         ar_drop = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] m, input logic [7:0] l);
        q_m.push_back(m);
        q_l.push_back(l);
    endtask

    // Monitor: each drain handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && s_valid && s_ready) begin
            if (q_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", s);
            end else begin
                chk("word_msb", s, q_m.pop_front());
                chk("word_lsb", s_l, q_l.pop_front());
                chk("valid_lsb", s_valid_l, 1'b1);
            end
            if (stream_on) drain_t.push_back(cyc);
        end
        if (stream_on && !a_ready) ar_drop = 1'b1;
    end

    task automatic send_bit(input logic b);
        logic rdy;
        a       = b;
        a_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = a_ready;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got a_ready=0 expected 1");
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(w[i]);
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        a_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(2);

        // Reset state
        @(negedge clk);
        chk("rst_s", s, 8'h00);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_cnt", cnt, 3'd0);
        chk("rst_a_ready", a_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single word, both bit orders
        s_ready = 1'b1;
        push(8'hB2, 8'h4D);
        send_bits(8'hB2, 8);
        a_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", s_valid, 1'b1);
        chk("single_cnt", cnt, 3'd0);
        @(negedge clk);
        chk("single_one_cycle", s_valid, 1'b0);
        @(posedge clk);
        #1;

        // Backpressure
        s_ready = 1'b0;
        push(8'hB2, 8'h4D);
        send_bits(8'hB2, 8);
        push(8'h5A, 8'h5A);
        send_bits(8'h5A, 7);
        a       = 1'b0;
        a_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_a_ready", a_ready, 1'b0);
        chk("bp_cnt", cnt, 3'd7);
        chk("bp_held_valid", s_valid, 1'b1);
        chk("bp_held_s", s, 8'hB2);
        @(posedge clk);
        #1;
        s_ready = 1'b1;
        @(posedge clk);
        #1;
        s_ready = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_s", s, 8'h5A);
        chk("bp_new_valid", s_valid, 1'b1);
        chk("bp_new_cnt", cnt, 3'd0);
        @(posedge clk);
        #1;
        s_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Continuous streaming
        drain_t.delete();
        ar_drop   = 1'b0;
        stream_on = 1'b1;
        push(8'h12, 8'h48);
        push(8'h34, 8'h2C);
        push(8'hA5, 8'hA5);
        push(8'hF0, 8'h0F);
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        send_bits(8'hA5, 8);
        send_bits(8'hF0, 8);
        a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        stream_on = 1'b0;
        chk("stream_words", drain_t.size(), 4);
        for (int i = 1; i < drain_t.size(); i++)
            chk("stream_spacing", drain_t[i] - drain_t[i-1], 8);
        chk("stream_no_stall", ar_drop, 1'b0);

        // Mid-word reset
        send_bits(8'hFF, 5);
        a_valid = 1'b0;
        do_reset(1);
        @(negedge clk);
        chk("mid_rst_cnt", cnt, 3'd0);
        chk("mid_rst_valid", s_valid, 1'b0);
        @(posedge clk);
        #1;
        push(8'hC3, 8'hC3);
        send_bits(8'hC3, 8);
        a_valid = 1'b0;

        for (int k = 0; k < 20 && q_m.size() != 0; k++) @(posedge clk);
        #1;
        chk("queue_drained", q_m.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser2par_reg.md
Name: ser2par_reg

Overview:
- Serial-to-parallel register stage that sits directly downstream of the single-bit D flip-flop.
- Consumes one registered bit per accepted cycle and assembles WIDTH bits into a word.
- Presents the word on a one-entry output holding register with a valid/ready handshake.
- This is the first multi-bit storage stage in the logic library; it is built from the same D flip-flop behaviour.

Parameters:
- WIDTH, 8: number of bits per assembled word; legal range is 2 or greater.
- MSB_FIRST, 1: if 1, the first accepted bit lands in s[WIDTH-1]. If 0, the first accepted bit lands in s[0].

Ports:
- clk  input  1  rising-edge clock. This is the only clock.
- rst  input  1  synchronous, active-high reset.
- a  input  1  serial data bit.
- a_valid  input  1  a holds a bit to be accepted.
- a_ready  output  1  the stage can accept a bit this cycle.
- s  output  WIDTH  assembled parallel word.
- s_valid  output  1  s holds a complete word.
- s_ready  input  1  the downstream stage consumes s this cycle.
- cnt  output  clog2(WIDTH)  number of bits accepted into the current partial word.

Behaviour:
- Reset: rst is sampled on the rising edge of clk. Reset values: s=0, s_valid=0, cnt=0, internal shift register=0.
  - Reset overrides every other input in that cycle.
  - A partial word is discarded when rst is asserted mid-word.
- Transfer rules:
  - An input bit is accepted when a_valid and a_ready are both 1 on a clk edge.
  - A word is drained when s_valid and s_ready are both 1 on a clk edge.
- Shifting:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], a}.
  - MSB_FIRST=0: sh <= {a, sh[WIDTH-1:1]}.
- Counter: cnt increments on each accepted bit. It wraps from WIDTH-1 back to 0 when the final bit of a word is accepted.
- Word completion: when the final bit is accepted (cnt==WIDTH-1), the word including that bit loads into s on the same edge. s_valid is 1 in the following cycle.
  - Latency: first output at the edge of the final accepted bit, visible in the next cycle.
  - Sustained throughput: one word per WIDTH accepted bits, with no bubble.
- a_ready is combinational: a_ready = (cnt != WIDTH-1) | !s_valid | s_ready.
  - Partial-word bits are never stalled.
  - Only the word-completing bit stalls, and only while the output slot is full and not being drained.
- Simultaneous drain and load: when a drain and a word completion occur on the same edge, s takes the new word and s_valid stays 1.
- Drain only: s_valid <= 0 and s holds its last value. s is don't-care for consumers while s_valid=0.
- Stability: while s_valid=1 and s_ready=0, s and s_valid are held stable. No bits are dropped or overwritten.
- a_valid=0: sh and cnt hold.
- a_ready does not depend on a_valid, so there is no combinational loop. s_ready may depend on s_valid.

Test Plan:
- Reset check (WIDTH=8, MSB_FIRST=1): rst for 2 cycles, then idle -> s=0x00, s_valid=0, cnt=0, a_ready=1.
- Single word MSB-first: a = 1,0,1,1,0,0,1,0 on consecutive cycles with a_valid=1 and s_ready=1 -> s=0xB2 and s_valid=1 for exactly one cycle, starting the cycle after the 8th bit; cnt returns to 0.
- Same bit stream with MSB_FIRST=0 -> s=0x4D.
- Backpressure with s_ready=0: stream 16 bits (0xB2 then 0x5A).
  - First word: s=0xB2 is held.
  - Second word: 7 bits are accepted, then a_ready=0 with cnt=7.
  - On raising s_ready for one cycle: 0xB2 drains, the held 8th bit is accepted on that same edge, and s=0x5A with s_valid=1 next cycle.
- Continuous streaming: 32 back-to-back bits with s_ready=1 -> 4 words emitted, each exactly 8 cycles apart; a_ready never drops.
- Mid-word reset: accept 5 bits, assert rst for 1 cycle, then send a full word 0xC3 -> output is 0xC3, with no residue from the partial word.
